// File: rtl/scr1_dtm_tap_sync.sv
// JTAG TAP controller run on the debug clock: oversamples the JTAG pins, runs the
// 16-state TAP FSM and drives single-clk capture/shift/update pulses on the DTM chain.
module scr1_dtm_tap_sync #(
  parameter int unsigned IR_WIDTH     = 5,
  parameter logic [31:0] IDCODE_VALUE = 32'hDEB11001,
  parameter int unsigned CH_ID_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jtag_tck,
  input  logic                   jtag_tms,
  input  logic                   jtag_tdi,
  output logic                   jtag_tdo,
  output logic                   jtag_tdo_en,
  output logic                   dtm_ch_sel,
  output logic [CH_ID_WIDTH-1:0] dtm_ch_id,
  output logic                   dtm_ch_capture,
  output logic                   dtm_ch_shift,
  output logic                   dtm_ch_update,
  output logic                   dtm_ch_tdi,
  input  logic                   dtm_ch_tdo
);

  localparam int unsigned IDCODE_W = 32;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
  localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
  localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e state_q, state_d;

  logic tck_s1_q, tck_s2_q, tck_prev_q;
  logic tms_s1_q, tms_s2_q;
  logic tdi_s1_q, tdi_s2_q;
  logic rise, fall;

  logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
  logic [IDCODE_W-1:0] idcode_sr_q;
  logic                bypass_q;
  logic                tdo_q, tdo_en_q;
  logic                is_idcode, is_dtmcs, is_dmi;
  logic                dr_tdo;

  // Pin synchronizers plus a third tck stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_s1_q   <= 1'b0;
      tck_s2_q   <= 1'b0;
      tck_prev_q <= 1'b0;
      tms_s1_q   <= 1'b1;
      tms_s2_q   <= 1'b1;
      tdi_s1_q   <= 1'b0;
      tdi_s2_q   <= 1'b0;
    end else begin
      tck_s1_q   <= jtag_tck;
      tck_s2_q   <= tck_s1_q;
      tck_prev_q <= tck_s2_q;
      tms_s1_q   <= jtag_tms;
      tms_s2_q   <= tms_s1_q;
      tdi_s1_q   <= jtag_tdi;
      tdi_s2_q   <= tdi_s1_q;
    end
  end

  assign rise = tck_s2_q & ~tck_prev_q;
  assign fall = ~tck_s2_q & tck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TLR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rise) begin
      unique case (state_q)
        TLR:      state_d = tms_s2_q ? TLR    : RTI;
        RTI:      state_d = tms_s2_q ? SEL_DR : RTI;
        SEL_DR:   state_d = tms_s2_q ? SEL_IR : CAP_DR;
        CAP_DR:   state_d = tms_s2_q ? EX1_DR : SH_DR;
        SH_DR:    state_d = tms_s2_q ? EX1_DR : SH_DR;
        EX1_DR:   state_d = tms_s2_q ? UPD_DR : PAUSE_DR;
        PAUSE_DR: state_d = tms_s2_q ? EX2_DR : PAUSE_DR;
        EX2_DR:   state_d = tms_s2_q ? UPD_DR : SH_DR;
        UPD_DR:   state_d = tms_s2_q ? SEL_DR : RTI;
        SEL_IR:   state_d = tms_s2_q ? TLR    : CAP_IR;
        CAP_IR:   state_d = tms_s2_q ? EX1_IR : SH_IR;
        SH_IR:    state_d = tms_s2_q ? EX1_IR : SH_IR;
        EX1_IR:   state_d = tms_s2_q ? UPD_IR : PAUSE_IR;
        PAUSE_IR: state_d = tms_s2_q ? EX2_IR : PAUSE_IR;
        EX2_IR:   state_d = tms_s2_q ? UPD_IR : SH_IR;
        UPD_IR:   state_d = tms_s2_q ? SEL_DR : RTI;
        default:  state_d = TLR;
      endcase
    end
  end

  assign is_idcode = (ir_q == IR_IDCODE);
  assign is_dtmcs  = (ir_q == IR_DTMCS);
  assign is_dmi    = (ir_q == IR_DMI);

  // IR: forced to IDCODE while in TLR, otherwise loaded from the shift stage on update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= IR_IDCODE;
      ir_sr_q <= '0;
    end else begin
      if (rise && state_q == CAP_IR)     ir_sr_q <= IR_WIDTH'(1);
      else if (rise && state_q == SH_IR) ir_sr_q <= {tdi_s2_q, ir_sr_q[IR_WIDTH-1:1]};
      if (state_q == TLR)                ir_q <= IR_IDCODE;
      else if (fall && state_q == UPD_IR) ir_q <= ir_sr_q;
    end
  end

  // Internal DRs; unknown instructions fall through to BYPASS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idcode_sr_q <= '0;
      bypass_q    <= 1'b0;
    end else if (rise && state_q == CAP_DR) begin
      if (is_idcode) idcode_sr_q <= IDCODE_VALUE;
      bypass_q <= 1'b0;
    end else if (rise && state_q == SH_DR) begin
      if (is_idcode) idcode_sr_q <= {tdi_s2_q, idcode_sr_q[IDCODE_W-1:1]};
      bypass_q <= tdi_s2_q;
    end
  end

  always_comb begin
    dr_tdo = bypass_q;
    if (dtm_ch_sel)     dr_tdo = dtm_ch_tdo;
    else if (is_idcode) dr_tdo = idcode_sr_q[0];
  end

  // TDO and its enable change only on tck falling edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else if (fall) begin
      tdo_en_q <= (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR)      tdo_q <= ir_sr_q[0];
      else if (state_q == SH_DR) tdo_q <= dr_tdo;
    end
  end

  assign jtag_tdo       = tdo_q;
  assign jtag_tdo_en    = tdo_en_q;
  assign dtm_ch_sel     = is_dtmcs | is_dmi;
  assign dtm_ch_id      = is_dtmcs ? CH_ID_WIDTH'(1) : (is_dmi ? CH_ID_WIDTH'(2) : CH_ID_WIDTH'(0));
  assign dtm_ch_capture = dtm_ch_sel & rise & (state_q == CAP_DR);
  assign dtm_ch_shift   = dtm_ch_sel & rise & (state_q == SH_DR);
  assign dtm_ch_update  = dtm_ch_sel & fall & (state_q == UPD_DR);
  assign dtm_ch_tdi     = tdi_s2_q;

endmodule

// File: tb/tb_scr1_dtm_tap_sync.sv
// Bench for scr1_dtm_tap_sync: drives JTAG pin sequences and models the DMI chain.
module tb_scr1_dtm_tap_sync;

  localparam int unsigned HALF    = 6;
  localparam logic [31:0] IDCODE  = 32'hDEB11001;
  localparam logic [40:0] CAP_VAL = 41'h123_4567_89AB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       jtag_tck, jtag_tms, jtag_tdi;
  logic       jtag_tdo, jtag_tdo_en;
  logic       dtm_ch_sel;
  logic [1:0] dtm_ch_id;
  logic       dtm_ch_capture, dtm_ch_shift, dtm_ch_update, dtm_ch_tdi;
  logic       dtm_ch_tdo;

  int errors = 0;
  int checks = 0;

  logic        tdo_s, en_s;
  int          cap_cnt = 0, sh_cnt = 0, upd_cnt = 0, excl_err = 0, nosel_err = 0;
  logic [40:0] chain = '0;
  logic [40:0] last_upd = '0;
  logic        obs_tdi[$];
  logic        exp_tdi[$];

  scr1_dtm_tap_sync dut (
    .clk(clk), .rst_n(rst_n),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo), .jtag_tdo_en(jtag_tdo_en),
    .dtm_ch_sel(dtm_ch_sel), .dtm_ch_id(dtm_ch_id),
    .dtm_ch_capture(dtm_ch_capture), .dtm_ch_shift(dtm_ch_shift),
    .dtm_ch_update(dtm_ch_update), .dtm_ch_tdi(dtm_ch_tdi),
    .dtm_ch_tdo(dtm_ch_tdo)
  );

  always #5 clk = ~clk;

  assign dtm_ch_tdo = chain[0];

  // DMI-chain model and pulse monitor
  always @(negedge clk) begin
    if ((int'(dtm_ch_capture) + int'(dtm_ch_shift) + int'(dtm_ch_update)) > 1) excl_err++;
    if ((dtm_ch_capture || dtm_ch_shift || dtm_ch_update) && !dtm_ch_sel) nosel_err++;
    if (dtm_ch_capture) begin
      cap_cnt++;
      chain = CAP_VAL;
    end
    if (dtm_ch_shift) begin
      sh_cnt++;
      obs_tdi.push_back(dtm_ch_tdi);
      chain = {dtm_ch_tdi, chain[40:1]};
    end
    if (dtm_ch_update) begin
      upd_cnt++;
      last_upd = chain;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tck period; TDO is sampled just before the rising edge
  task automatic tck(input logic tms, input logic tdi);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (HALF) @(negedge clk);
    tdo_s = jtag_tdo;
    en_s  = jtag_tdo_en;
    jtag_tck = 1'b1;
    repeat (HALF) @(negedge clk);
    jtag_tck = 1'b0;
  endtask

  // RTI -> shift IR -> update -> RTI, returns captured bits seen on TDO
  task automatic load_ir(input logic [4:0] code, output logic [4:0] cap);
    tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tck(i == 4, code[i]);
      cap[i] = tdo_s;
    end
    tck(1'b1, 1'b0); tck(1'b0, 1'b0);
    idle(HALF);
  endtask

  // RTI -> shift DR n bits -> update -> RTI
  task automatic dr_scan(input int n, input logic [63:0] din, input bit chain_exp,
                         output logic [63:0] dout, output logic en_ok);
    dout  = '0;
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    en_ok = (en_s == 1'b0);
    for (int i = 0; i < n; i++) begin
      if (chain_exp) exp_tdi.push_back(din[i]);
      tck(i == n - 1, din[i]);
      dout[i] = tdo_s;
      if (en_s !== 1'b1) en_ok = 1'b0;
    end
    tck(1'b1, 1'b0);
    if (en_s !== 1'b0) en_ok = 1'b0;
    tck(1'b0, 1'b0);
    idle(HALF);
  endtask

  task automatic compare_tdi_queues(input string name);
    int bad = 0;
    checks++;
    if (obs_tdi.size() != exp_tdi.size()) bad = 1000;
    while (obs_tdi.size() > 0 && exp_tdi.size() > 0)
      if (obs_tdi.pop_front() !== exp_tdi.pop_front()) bad++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d tdi mismatches (1000+ means count differs)", name, bad);
    end
    obs_tdi.delete();
    exp_tdi.delete();
  endtask

  // From TLR, read 32 IDCODE bits and check no chain activity
  task automatic read_idcode(input string name);
    logic [63:0] d;
    logic ok;
    int c0, s0, u0;
    c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
    tck(1'b0, 1'b0);
    dr_scan(32, 64'h0, 1'b0, d, ok);
    checks++;
    if (d[31:0] !== IDCODE) begin
      errors++; $display("FAIL %s idcode: got %h want %h", name, d[31:0], IDCODE);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL %s tdo_en: got window-ok %b want 1", name, ok);
    end
    checks++;
    if ((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0) != 0) begin
      errors++; $display("FAIL %s pulses: got %0d want 0", name, (cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0));
    end
  endtask

  task automatic test_reset();
    jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0; rst_n = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(5);
    checks++;
    if ({jtag_tdo, jtag_tdo_en, dtm_ch_sel, dtm_ch_id} !== 5'b0) begin
      errors++; $display("FAIL reset outputs: got %b want 00000", {jtag_tdo, jtag_tdo_en, dtm_ch_sel, dtm_ch_id});
    end
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    idle(HALF);
    read_idcode("reset_idcode");
  endtask

  task automatic test_ir_scan();
    logic [4:0] cap;
    load_ir(5'h10, cap);
    checks++;
    if ({dtm_ch_sel, dtm_ch_id} !== 3'b101) begin
      errors++; $display("FAIL ir_dtmcs sel/id: got %b want 101", {dtm_ch_sel, dtm_ch_id});
    end
    load_ir(5'h11, cap);
    checks++;
    if (cap !== 5'b00001) begin
      errors++; $display("FAIL ir_capture: got %b want 00001", cap);
    end
    checks++;
    if ({dtm_ch_sel, dtm_ch_id} !== 3'b110) begin
      errors++; $display("FAIL ir_dmi sel/id: got %b want 110", {dtm_ch_sel, dtm_ch_id});
    end
  endtask

  task automatic test_dmi_scan();
    logic [40:0] req;
    logic [63:0] d;
    logic ok;
    int c0, s0, u0;
    req = {7'h04, 32'hA5A5_0001, 2'd2};
    obs_tdi.delete(); exp_tdi.delete();
    c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
    dr_scan(41, 64'(req), 1'b1, d, ok);
    checks++;
    if ({cap_cnt - c0, sh_cnt - s0, upd_cnt - u0} !== {32'd1, 32'd41, 32'd1}) begin
      errors++; $display("FAIL dmi_pulses: got cap=%0d sh=%0d upd=%0d want 1/41/1", cap_cnt - c0, sh_cnt - s0, upd_cnt - u0);
    end
    compare_tdi_queues("dmi_tdi");
    checks++;
    if (d[40:0] !== CAP_VAL) begin
      errors++; $display("FAIL dmi_tdo: got %h want %h", d[40:0], CAP_VAL);
    end
    checks++;
    if (last_upd[40:34] !== 7'h04 || last_upd[1:0] !== 2'd2 || last_upd[33:2] !== 32'hA5A5_0001) begin
      errors++; $display("FAIL dmi_write: got %h want %h", last_upd, req);
    end
  endtask

  task automatic test_exit_no_scan();
    int c0, s0, u0;
    c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0);
    idle(HALF);
    checks++;
    if ({cap_cnt - c0, sh_cnt - s0, upd_cnt - u0} !== {32'd1, 32'd0, 32'd1}) begin
      errors++; $display("FAIL exit_no_scan: got cap=%0d sh=%0d upd=%0d want 1/0/1", cap_cnt - c0, sh_cnt - s0, upd_cnt - u0);
    end
  endtask

  task automatic test_bypass(input logic [4:0] code);
    logic [4:0] cap;
    logic [63:0] d;
    logic [7:0] pat, want;
    logic ok;
    int p0;
    pat = 8'b11001101;   // shifted LSB first: 1,0,1,1,0,0,1,1
    want = {pat[6:0], 1'b0};
    load_ir(code, cap);
    p0 = cap_cnt + sh_cnt + upd_cnt;
    dr_scan(8, 64'(pat), 1'b0, d, ok);
    checks++;
    if (d[7:0] !== want) begin
      errors++; $display("FAIL bypass_%h echo: got %b want %b", code, d[7:0], want);
    end
    checks++;
    if (cap_cnt + sh_cnt + upd_cnt != p0 || dtm_ch_sel !== 1'b0) begin
      errors++; $display("FAIL bypass_%h pulses: got %0d sel=%b want 0 sel=0", code, cap_cnt + sh_cnt + upd_cnt - p0, dtm_ch_sel);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [4:0] cap;
    logic [40:0] req;
    int u0;
    req = {7'h10, 32'h1234_5678, 2'd2};
    load_ir(5'h11, cap);
    obs_tdi.delete(); exp_tdi.delete();
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_tdi.push_back(req[i]);
      tck(1'b0, req[i]);
    end
    u0 = upd_cnt;
    jtag_tms = 1'b1;
    idle(2);
    rst_n = 1'b0;
    idle(2);
    checks++;
    if ({jtag_tdo_en, dtm_ch_sel, dtm_ch_id} !== 4'b0) begin
      errors++; $display("FAIL midreset outputs: got %b want 0000", {jtag_tdo_en, dtm_ch_sel, dtm_ch_id});
    end
    rst_n = 1'b1;
    idle(20);
    compare_tdi_queues("midreset_tdi");
    checks++;
    if (upd_cnt != u0) begin
      errors++; $display("FAIL midreset update: got %0d want 0", upd_cnt - u0);
    end
    read_idcode("midreset_idcode");
  endtask

  task automatic test_tlr_recovery();
    logic [4:0] cap;
    load_ir(5'h11, cap);
    tck(1'b1, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b1);
    idle(HALF);
    checks++;
    if ({dtm_ch_sel, dtm_ch_id} !== 3'b000) begin
      errors++; $display("FAIL tlr_from_shift_ir sel/id: got %b want 000", {dtm_ch_sel, dtm_ch_id});
    end
    read_idcode("tlr_shift_ir_idcode");
    load_ir(5'h11, cap);
    tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    idle(HALF);
    checks++;
    if ({dtm_ch_sel, dtm_ch_id} !== 3'b000) begin
      errors++; $display("FAIL tlr_from_pause_dr sel/id: got %b want 000", {dtm_ch_sel, dtm_ch_id});
    end
    read_idcode("tlr_pause_dr_idcode");
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (excl_err != 0 || nosel_err != 0) begin
      errors++; $display("FAIL pulse_rules: got overlap=%0d unselected=%0d want 0/0", excl_err, nosel_err);
    end
  endtask

  initial begin
    test_reset();
    test_ir_scan();
    test_dmi_scan();
    test_exit_no_scan();
    test_bypass(5'h1F);
    test_bypass(5'h07);
    test_reset_mid_scan();
    test_tlr_recovery();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
